// File: rtl/y86_pipe_pkg.sv
// Shared Y86-64 pipeline definitions: default widths, icodes, register IDs,
// status codes and the writeback-register action selection.
package y86_pipe_pkg;

   localparam int DATA_W_DEF  = 64;
   localparam int REG_W_DEF   = 4;
   localparam int ICODE_W_DEF = 4;
   localparam int STAT_W_DEF  = 3;
   localparam int CNT_W_DEF   = 32;

   localparam int unsigned IHALT   = 0;
   localparam int unsigned INOP    = 1;
   localparam int unsigned IRRMOVQ = 2;
   localparam int unsigned IIRMOVQ = 3;
   localparam int unsigned IRMMOVQ = 4;
   localparam int unsigned IMRMOVQ = 5;
   localparam int unsigned IOPQ    = 6;
   localparam int unsigned IJXX    = 7;
   localparam int unsigned ICALL   = 8;
   localparam int unsigned IRET    = 9;
   localparam int unsigned IPUSHQ  = 10;
   localparam int unsigned IPOPQ   = 11;

   localparam int unsigned RNONE = 15;

   localparam int unsigned SAOK = 1;
   localparam int unsigned SHLT = 2;
   localparam int unsigned SADR = 3;
   localparam int unsigned SINS = 4;

   typedef enum logic [1:0] {
      WB_FREEZE,
      WB_HOLD,
      WB_BUBBLE,
      WB_LOAD
   } wb_action_e;

   // Freeze outranks stall, and stall outranks bubble.
   function automatic wb_action_e wbAction(input logic halted,
                                           input logic stall,
                                           input logic bubble);
      wb_action_e act;
      act = WB_LOAD;
      if (halted)
         act = WB_FREEZE;
      else if (stall)
         act = WB_HOLD;
      else if (bubble)
         act = WB_BUBBLE;
      return act;
   endfunction

endpackage

// File: rtl/wb_stage_reg_if.sv
// Memory-to-writeback bundle: pipeline control and m_* inputs, W_* outputs.
// W_retired exists only when WB_RETIRE_CNT_EN is defined.
interface wb_stage_reg_if
   import y86_pipe_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_W   = REG_W_DEF,
   parameter int ICODE_W = ICODE_W_DEF,
   parameter int STAT_W  = STAT_W_DEF
`ifdef WB_RETIRE_CNT_EN
   ,
   parameter int CNT_W   = CNT_W_DEF
`endif
);

   logic               W_stall;
   logic               W_bubble;
   logic               m_valid;
   logic [STAT_W-1:0]  m_stat;
   logic [ICODE_W-1:0] m_icode;
   logic [DATA_W-1:0]  m_valE;
   logic [DATA_W-1:0]  m_valM;
   logic [REG_W-1:0]   m_dstE;
   logic [REG_W-1:0]   m_dstM;

   logic               W_valid;
   logic [STAT_W-1:0]  W_stat;
   logic [ICODE_W-1:0] W_icode;
   logic [DATA_W-1:0]  W_valE;
   logic [DATA_W-1:0]  W_valM;
   logic [REG_W-1:0]   W_dstE;
   logic [REG_W-1:0]   W_dstM;
   logic               W_weE;
   logic               W_weM;
   logic               W_halted;
`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0]   W_retired;
`endif

   modport master (
      output W_stall, W_bubble, m_valid, m_stat, m_icode,
             m_valE, m_valM, m_dstE, m_dstM,
      input  W_valid, W_stat, W_icode, W_valE, W_valM,
             W_dstE, W_dstM, W_weE, W_weM, W_halted
`ifdef WB_RETIRE_CNT_EN
      ,
      input  W_retired
`endif
   );

   modport slave (
      input  W_stall, W_bubble, m_valid, m_stat, m_icode,
             m_valE, m_valM, m_dstE, m_dstM,
      output W_valid, W_stat, W_icode, W_valE, W_valM,
             W_dstE, W_dstM, W_weE, W_weM, W_halted
`ifdef WB_RETIRE_CNT_EN
      ,
      output W_retired
`endif
   );

endinterface

// File: rtl/wb_stage_reg_retire_counter.sv
// Saturating retired-instruction counter with async reset and increment enable.
module retire_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Sticks at all-ones so a long run never wraps back to a small count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (i_inc && (r_count != '1))
         r_count <= r_count + CNT_W'(1);
   end

   assign o_count = r_count;

endmodule

// File: rtl/wb_stage_reg.sv
// Y86-64 memory-to-writeback pipeline register with stall, bubble and
// exception freeze. WB_RETIRE_CNT_EN adds the retired-instruction counter.
module wb_stage_reg
   import y86_pipe_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_W   = REG_W_DEF,
   parameter int ICODE_W = ICODE_W_DEF,
   parameter int STAT_W  = STAT_W_DEF
`ifdef WB_RETIRE_CNT_EN
   ,
   parameter int CNT_W   = CNT_W_DEF
`endif
) (
   input logic           clk,
   input logic           rst,
   wb_stage_reg_if.slave bus
);

   localparam logic [STAT_W-1:0]  L_SAOK  = STAT_W'(SAOK);
   localparam logic [ICODE_W-1:0] L_INOP  = ICODE_W'(INOP);
   localparam logic [REG_W-1:0]   L_RNONE = '1;

   logic               r_valid;
   logic [STAT_W-1:0]  r_stat;
   logic [ICODE_W-1:0] r_icode;
   logic [DATA_W-1:0]  r_valE;
   logic [DATA_W-1:0]  r_valM;
   logic [REG_W-1:0]   r_dstE;
   logic [REG_W-1:0]   r_dstM;

   logic               w_halted;
   logic               w_statOk;
   wb_action_e         w_action;

   // A non-AOK status in W can only be left through reset, which is what
   // makes the freeze sticky.
   assign w_statOk = (r_stat == L_SAOK);
   assign w_halted = ~w_statOk;

   always_comb begin
      w_action = WB_LOAD;
      w_action = wbAction(w_halted, bus.W_stall, bus.W_bubble);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_stat  <= L_SAOK;
         r_icode <= L_INOP;
         r_valE  <= '0;
         r_valM  <= '0;
         r_dstE  <= L_RNONE;
         r_dstM  <= L_RNONE;
      end else begin
         case (w_action)
            WB_BUBBLE: begin
               r_valid <= 1'b0;
               r_stat  <= L_SAOK;
               r_icode <= L_INOP;
               r_valE  <= '0;
               r_valM  <= '0;
               r_dstE  <= L_RNONE;
               r_dstM  <= L_RNONE;
            end
            WB_LOAD: begin
               r_valid <= bus.m_valid;
               r_stat  <= bus.m_stat;
               r_icode <= bus.m_icode;
               r_valE  <= bus.m_valE;
               r_valM  <= bus.m_valM;
               r_dstE  <= bus.m_dstE;
               r_dstM  <= bus.m_dstM;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.W_valid  = r_valid;
   assign bus.W_stat   = r_stat;
   assign bus.W_icode  = r_icode;
   assign bus.W_valE   = r_valE;
   assign bus.W_valM   = r_valM;
   assign bus.W_dstE   = r_dstE;
   assign bus.W_dstM   = r_dstM;
   assign bus.W_halted = w_halted;

   // Bubbles and excepting instructions never reach the register file.
   assign bus.W_weE = r_valid & w_statOk & (r_dstE != L_RNONE);
   assign bus.W_weM = r_valid & w_statOk & (r_dstM != L_RNONE);

`ifdef WB_RETIRE_CNT_EN
   logic w_retire;

   assign w_retire = (w_action == WB_LOAD) & bus.m_valid & (bus.m_stat == L_SAOK);

   retire_counter #(
      .CNT_W (CNT_W)
   ) u_retireCounter (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_retire),
      .o_count (bus.W_retired)
   );
`endif

endmodule
